// File: rtl/emissor_sequencia_if.sv
// Digit-entry bus between the sequence emitter and its driver.
// The code-store write port, the start/abort controls and the registered playback outputs.
interface emissor_sequencia_if;
    logic       load;
    logic [3:0] load_idx;
    logic [3:0] load_digit;
    logic       start;
    logic       abort;
    logic [4:1] numero;
    logic       insere;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] idx;

    modport master (
        output load, load_idx, load_digit, start, abort,
        input  numero, insere, busy, done, err, idx
    );

    modport slave (
        input  load, load_idx, load_digit, start, abort,
        output numero, insere, busy, done, err, idx
    );
endinterface

// File: rtl/emissor_sequencia.sv
// Plays a stored code as a sequence of insere-qualified digits; every output is registered.
// There is no backpressure: start is taken only in IDLE, and abort returns to IDLE on the next edge.
module emissor_sequencia #(
    parameter int N_DIGITS = 4,
    parameter int HOLD     = 1,
    parameter int GAP      = 2
) (
    input  logic                clk,
    input  logic                reset,
    emissor_sequencia_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [3:0]    LAST_IDX  = 4'(N_DIGITS - 1);

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [3:0]                 idx_q, idx_d;
    logic [3:0]                 numero_q, numero_d;
    logic                       insere_q, insere_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [N_DIGITS-1:0][3:0]   code_q, code_d;
    logic [3:0]                 sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        numero_d = numero_q;
        err_d    = err_q;
        code_d   = code_q;
        sel      = '0;

        // Writes land before the start transition so a same-cycle start sees the new digit.
        if (state_q == S_IDLE && bus.load) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (bus.load_idx == 4'(i)) code_d[i] = bus.load_digit;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_SETUP;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else if (GAP == 0) begin
                        state_d = S_SETUP;
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SETUP;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end

        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == 4'(i)) sel = code_d[i];
        end

        // Out-of-range digits are still emitted; they only raise the sticky flag.
        if (state_d == S_SETUP) begin
            numero_d = sel;
            if (sel > 4'd9) err_d = 1'b1;
        end

        insere_d = (state_d == S_STROBE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            numero_q <= '0;
            insere_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            numero_q <= numero_d;
            insere_q <= insere_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign bus.numero = numero_q;
    assign bus.insere = insere_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.idx    = idx_q;

endmodule

// File: tb/tb_emissor_sequencia.sv
// Bench for emissor_sequencia: the default timing (a) and HOLD=2/GAP=0 (b) share one stimulus stream.
// Expected waveforms come from the cycle-since-start arithmetic of the playback timing rules.
module tb_emissor_sequencia;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_idx = '0;
    logic [3:0] load_digit = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;

    int total = 0;
    int bad   = 0;

    emissor_sequencia_if ifa ();
    emissor_sequencia_if ifb ();

    assign ifa.load = load;  assign ifa.load_idx = load_idx;  assign ifa.load_digit = load_digit;
    assign ifa.start = start; assign ifa.abort = abort;
    assign ifb.load = load;  assign ifb.load_idx = load_idx;  assign ifb.load_digit = load_digit;
    assign ifb.start = start; assign ifb.abort = abort;

    emissor_sequencia dut_a (.clk(clk), .reset(reset), .bus(ifa));
    emissor_sequencia #(.N_DIGITS(4), .HOLD(2), .GAP(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference: each instance is either idle or n cycles into a playback.
    logic [3:0] code_m [2][4];
    bit         run_m  [2];
    int         n_m    [2];
    logic [3:0] num_m  [2];
    logic [3:0] idx_m  [2];
    bit         err_m  [2];

    function automatic int hd(int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int gp(int d); return (d == 0) ? 2 : 0; endfunction
    function automatic int per(int d); return 1 + hd(d) + gp(d); endfunction
    function automatic int tot(int d); return 4 * (1 + hd(d)) + 3 * gp(d) + 1; endfunction

    function automatic int kof(int d, int n);
        if (n >= tot(d)) return 3;
        return (n - 1) / per(d);
    endfunction

    function automatic logic [3:0] exp_num(int d, int n);
        return code_m[d][kof(d, n)];
    endfunction

    function automatic bit exp_ins(int d, int n);
        int r;
        if (n >= tot(d)) return 1'b0;
        r = (n - 1) % per(d);
        return (r >= 1) && (r <= hd(d));
    endfunction

    function automatic bit exp_err(int d, int n);
        for (int j = 0; j <= kof(d, n); j++) begin
            if (code_m[d][j] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                run_m[d] <= 1'b0; n_m[d] <= 0; num_m[d] <= '0; idx_m[d] <= '0; err_m[d] <= 1'b0;
                for (int j = 0; j < 4; j++) code_m[d][j] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (run_m[d]) begin
                    if (abort || n_m[d] == tot(d)) begin
                        run_m[d] <= 1'b0;
                        num_m[d] <= exp_num(d, n_m[d]);
                        err_m[d] <= exp_err(d, n_m[d]);
                        idx_m[d] <= abort ? 4'd0 : 4'd3;
                    end else begin
                        n_m[d] <= n_m[d] + 1;
                    end
                end else begin
                    if (load && load_idx < 4'd4) code_m[d][load_idx[1:0]] <= load_digit;
                    if (start && !abort) begin
                        run_m[d] <= 1'b1;
                        n_m[d]   <= 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] gn [2];
        logic [3:0] gi [2];
        logic       gs [2];
        logic       gb [2];
        logic       gd [2];
        logic       ge [2];
        logic [3:0] en, ei;
        logic       es, eb, ed, ee;
        string      s;
        gn[0] = ifa.numero; gi[0] = ifa.idx; gs[0] = ifa.insere;
        gb[0] = ifa.busy;   gd[0] = ifa.done; ge[0] = ifa.err;
        gn[1] = ifb.numero; gi[1] = ifb.idx; gs[1] = ifb.insere;
        gb[1] = ifb.busy;   gd[1] = ifb.done; ge[1] = ifb.err;
        for (int d = 0; d < 2; d++) begin
            s = (d == 0) ? "a" : "b";
            if (run_m[d]) begin
                en = exp_num(d, n_m[d]); ei = 4'(kof(d, n_m[d])); es = exp_ins(d, n_m[d]);
                eb = 1'b1; ed = (n_m[d] == tot(d)); ee = exp_err(d, n_m[d]);
            end else begin
                en = num_m[d]; ei = idx_m[d]; es = 1'b0; eb = 1'b0; ed = 1'b0; ee = err_m[d];
            end
            chk({s, ".numero"}, 32'(gn[d]), 32'(en));
            chk({s, ".idx"},    32'(gi[d]), 32'(ei));
            chk({s, ".insere"}, 32'(gs[d]), 32'(es));
            chk({s, ".busy"},   32'(gb[d]), 32'(eb));
            chk({s, ".done"},   32'(gd[d]), 32'(ed));
            chk({s, ".err"},    32'(ge[d]), 32'(ee));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic load_slot(input logic [3:0] i, input logic [3:0] v);
        load = 1'b1; load_idx = i; load_digit = v;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            if (!ifa.busy && !ifb.busy) break;
            tick();
        end
        chk("wait_idle", 32'(ifa.busy | ifb.busy), 32'd0);
    endtask

    task automatic play_and_time(input int ea, input int eb);
        int lat, la, lb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; la = 0; lb = 0;
        for (int g = 0; g < 40; g++) begin
            if (ifa.done && la == 0) la = lat;
            if (ifb.done && lb == 0) lb = lat;
            if (la != 0 && lb != 0) break;
            tick();
            lat++;
        end
        chk("done_lat_a", 32'(la), 32'(ea));
        chk("done_lat_b", 32'(lb), 32'(eb));
    endtask

    task automatic chk_reset_vals(input string s);
        chk({s, ".a.numero"}, 32'(ifa.numero), 32'd0);
        chk({s, ".a.insere"}, 32'(ifa.insere), 32'd0);
        chk({s, ".a.busy"},   32'(ifa.busy),   32'd0);
        chk({s, ".a.done"},   32'(ifa.done),   32'd0);
        chk({s, ".a.err"},    32'(ifa.err),    32'd0);
        chk({s, ".a.idx"},    32'(ifa.idx),    32'd0);
        chk({s, ".b.numero"}, 32'(ifb.numero), 32'd0);
        chk({s, ".b.insere"}, 32'(ifb.insere), 32'd0);
        chk({s, ".b.busy"},   32'(ifb.busy),   32'd0);
        chk({s, ".b.err"},    32'(ifb.err),    32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Nominal code 5,9,0,9.
        load_slot(4'd0, 4'd5); load_slot(4'd1, 4'd9); load_slot(4'd2, 4'd0); load_slot(4'd3, 4'd9);
        play_and_time(15, 13);
        wait_idle();
        chk("err_clean", 32'(ifa.err), 32'd0);

        // Out-of-range third digit, then a clean replay clears err.
        load_slot(4'd2, 4'd12);
        load_slot(4'd7, 4'd3);
        play_and_time(15, 13);
        wait_idle();
        chk("err_set_a", 32'(ifa.err), 32'd1);
        chk("err_set_b", 32'(ifb.err), 32'd1);
        load_slot(4'd2, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("err_clr", 32'(ifa.err), 32'd0);
        wait_idle();

        // Abort in the gap after digit 1.
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        chk("gap_idx", 32'(ifa.idx), 32'd1);
        chk("gap_ins", 32'(ifa.insere), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_done", 32'(ifa.done), 32'd0);
        chk("abort_idx", 32'(ifa.idx), 32'd0);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("abort_start", 32'(ifa.busy), 32'd0);
        play_and_time(15, 13);
        wait_idle();

        // Load with start in the same cycle; writes and starts while busy are dropped.
        start = 1'b1; load = 1'b1; load_idx = 4'd0; load_digit = 4'd3;
        tick();
        start = 1'b0; load = 1'b0;
        chk("same_cycle_load", 32'(ifa.numero), 32'd3);
        repeat (3) tick();
        load = 1'b1; load_idx = 4'd1; load_digit = 4'd15; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        wait_idle();
        play_and_time(15, 13);
        wait_idle();

        // Asynchronous reset in the middle of a strobe.
        load_slot(4'd3, 4'd12);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (ifa.insere) break;
            tick();
        end
        chk("saw_strobe", 32'(ifa.insere), 32'd1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        play_and_time(15, 13);
        wait_idle();

        // Random traffic, including out-of-range slots and digits above 9.
        for (int c = 0; c < 400; c++) begin
            load       = ($urandom % 4) == 0;
            load_idx   = 4'($urandom % 6);
            load_digit = 4'($urandom % 16);
            start      = ($urandom % 8) == 0;
            abort      = ($urandom % 30) == 0;
            tick();
        end
        load = 1'b0; start = 1'b0; abort = 1'b0;
        wait_idle();
        play_and_time(15, 13);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
